// File: rtl/ws2812_bit_encoder.sv
// WS2812 single-wire NRZ serializer: 24-bit GRB words in (G7 first), one-word holding
// register for gap-free back-to-back pixels, and a latch low period after the last pixel.
module ws2812_bit_encoder #(
    parameter int unsigned T0H_CYCLES = 32,
    parameter int unsigned T1H_CYCLES = 64,
    parameter int unsigned BIT_CYCLES = 100,
    parameter int unsigned RST_CYCLES = 4000,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pixel_valid_in,
    input  logic [23:0] pixel_data_in,
    input  logic        pixel_last_in,
    output logic        pixel_ready_out,
    output logic        ws2812_data_out,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic        underrun_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, STALL, LATCH} state_t;

    localparam logic [CNT_WIDTH-1:0] T0H_CNT  = CNT_WIDTH'(T0H_CYCLES);
    localparam logic [CNT_WIDTH-1:0] T1H_CNT  = CNT_WIDTH'(T1H_CYCLES);
    localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(BIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RST_LAST = CNT_WIDTH'(RST_CYCLES - 1);

    state_t               state;
    logic                 hold_full;
    logic                 hold_last;
    logic [23:0]          hold_data;
    logic                 cur_last;
    logic [23:0]          shift_data;
    logic [4:0]           bit_idx;
    logic [CNT_WIDTH-1:0] bit_cnt;
    logic [CNT_WIDTH-1:0] rst_cnt;
    logic [CNT_WIDTH-1:0] high_cnt;

    logic accept;
    logic bit_end;
    logic word_end;
    logic load;
    logic hold_full_next;

    assign accept         = pixel_valid_in && pixel_ready_out;
    assign bit_end        = (state == SHIFT) && (bit_cnt == BIT_LAST);
    assign word_end       = bit_end && (bit_idx == 5'd0);
    // The shifter takes the held word when idle, stalled, or at the end of a non-final word.
    assign load           = hold_full && ((state == IDLE) || (state == STALL) || (word_end && !cur_last));
    assign hold_full_next = (hold_full && !load) || accept;
    assign high_cnt       = shift_data[23] ? T1H_CNT : T0H_CNT;

    // NOTE: all state here updates with non-blocking assignments so every branch reads
    // pre-edge values; blocking writes would make results depend on statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            hold_full       <= 1'b0;
            pixel_ready_out <= 1'b0;
            bit_idx         <= '0;
            bit_cnt         <= '0;
            rst_cnt         <= '0;
            ws2812_data_out <= 1'b0;
            busy_out        <= 1'b0;
            frame_done_out  <= 1'b0;
            underrun_out    <= 1'b0;
        end else begin
            hold_full       <= hold_full_next;
            pixel_ready_out <= !hold_full_next;
            ws2812_data_out <= (state == SHIFT) && (bit_cnt < high_cnt);
            busy_out        <= (state != IDLE);
            frame_done_out  <= 1'b0;
            underrun_out    <= 1'b0;

            unique case (state)
                IDLE, STALL: begin
                    if (load) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        bit_idx <= 5'd23;
                    end
                end
                SHIFT: begin
                    if (!bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        bit_cnt <= '0;
                        if (bit_idx != 5'd0) begin
                            bit_idx <= bit_idx - 1'b1;
                        end else if (cur_last) begin
                            state   <= LATCH;
                            rst_cnt <= '0;
                        end else if (hold_full) begin
                            bit_idx <= 5'd23;
                        end else begin
                            state        <= STALL;
                            underrun_out <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (rst_cnt == RST_LAST) begin
                        state          <= IDLE;
                        rst_cnt        <= '0;
                        frame_done_out <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the data path has no reset; its contents are only observed after a load
    // qualified by the reset-cleared hold_full flag and state.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            hold_data <= pixel_data_in;
            hold_last <= pixel_last_in;
        end
        if (load) begin
            shift_data <= hold_data;
            cur_last   <= hold_last;
        end else if (bit_end && (bit_idx != 5'd0)) begin
            shift_data <= {shift_data[22:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Scoreboard bench for ws2812_bit_encoder: the driver queues each accepted word, an
// independent monitor decodes the line back into words and checks data and start timing.
module tb_ws2812_bit_encoder;

    localparam int T0H = 32;
    localparam int T1H = 64;
    localparam int BITC = 100;
    localparam int RSTC = 4000;
    localparam int WORD = 24 * BITC;

    logic        clk;
    logic        rst_in;
    logic        pixel_valid_in;
    logic [23:0] pixel_data_in;
    logic        pixel_last_in;
    logic        pixel_ready_out;
    logic        ws2812_data_out;
    logic        busy_out;
    logic        frame_done_out;
    logic        underrun_out;

    ws2812_bit_encoder #(
        .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .BIT_CYCLES(BITC), .RST_CYCLES(RSTC), .CNT_WIDTH(16)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .pixel_valid_in (pixel_valid_in),
        .pixel_data_in  (pixel_data_in),
        .pixel_last_in  (pixel_last_in),
        .pixel_ready_out(pixel_ready_out),
        .ws2812_data_out(ws2812_data_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out),
        .underrun_out   (underrun_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        bit          last;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    int acc_cnt = 0, send_cnt = 0;
    int done_cnt = 0, und_cnt = 0, last_done = -1, last_und = -1;
    int exp_done = 0, exp_underrun = 0;
    int viol = 0, inj = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Handshake counter and producer-stability watch, sampled at the active edge.
    initial begin
        bit pv, pr;
        logic [23:0] pd;
        pv = 0; pr = 0; pd = '0;
        forever begin
            @(posedge clk);
            if (!rst_in && pixel_valid_in && pixel_ready_out) acc_cnt++;
            if (pv && !pr && pixel_valid_in && pixel_data_in != pd) viol++;
            pv = pixel_valid_in; pr = pixel_ready_out; pd = pixel_data_in;
        end
    end

    // Line decoder and scoreboard. A word's first rise is expected 2 cycles after its
    // accept, but no earlier than right after the previous word (or its latch) finishes.
    initial begin
        bit m_prev, m_have_prev, m_prev_last;
        int m_hi, m_nbits, m_bad, m_rise, m_first_rise, m_prev_rise, exp_rise;
        logic [23:0] m_word;
        exp_t e;
        m_prev = 0; m_have_prev = 0; m_prev_last = 0; m_hi = 0; m_nbits = 0; m_bad = 0;
        m_rise = 0; m_first_rise = 0; m_prev_rise = 0; m_word = '0;
        forever begin
            @(negedge clk);
            if (rst_in) begin
                m_prev = 0; m_nbits = 0; m_bad = 0; m_have_prev = 0;
            end else begin
                if (ws2812_data_out && !m_prev) begin
                    if (m_nbits == 0) m_first_rise = cyc;
                    else if (cyc - m_rise != BITC) m_bad++;
                    m_rise = cyc;
                    m_hi = 0;
                end
                if (ws2812_data_out) m_hi++;
                if (!ws2812_data_out && m_prev) begin
                    check("bit_high_len_legal", (m_hi == T0H || m_hi == T1H), 1);
                    m_word = {m_word[22:0], (m_hi == T1H)};
                    m_nbits++;
                    if (m_nbits == 24) begin
                        check("word_expected_present", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("word_data", m_word, e.data);
                            exp_rise = e.acc + 2;
                            if (m_have_prev) begin
                                if (m_prev_rise + (m_prev_last ? WORD + RSTC + 1 : WORD) > exp_rise)
                                    exp_rise = m_prev_rise + (m_prev_last ? WORD + RSTC + 1 : WORD);
                                if (!m_prev_last && e.acc + 2 > m_prev_rise + WORD) exp_underrun++;
                            end
                            check("word_start_cycle", m_first_rise, exp_rise);
                            check("word_bit_spacing", m_bad, 0);
                            if (e.last) exp_done++;
                            m_have_prev = 1; m_prev_rise = m_first_rise; m_prev_last = e.last;
                        end
                        m_nbits = 0; m_bad = 0;
                    end
                end
                m_prev = ws2812_data_out;
            end
            if (frame_done_out) begin done_cnt++; last_done = cyc; end
            if (underrun_out) begin und_cnt++; last_und = cyc; end
        end
    end

    // Starts and ends on a falling edge; acc is the rising edge on which the word was taken.
    task automatic send(input logic [23:0] d, input bit l, input bit track, input bit wiggle,
                        output int acc);
        bit r;
        int n;
        pixel_valid_in = 1'b1;
        pixel_last_in  = l;
        pixel_data_in  = d;
        if (wiggle && !pixel_ready_out) begin
            pixel_data_in = d ^ 24'h1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                inj++;
                if (i == 2 || pixel_ready_out) begin
                    pixel_data_in = d;
                    break;
                end
                pixel_data_in = d ^ 24'(i + 2);
            end
        end
        n = 0;
        acc = -1;
        forever begin
            r = pixel_ready_out;
            acc = cyc + 1;
            @(posedge clk);
            @(negedge clk);
            if (r) break;
            n++;
            if (n > 20000) begin
                check("accept_within_budget", n, 0);
                break;
            end
        end
        check("ready_drop_after_accept", pixel_ready_out, 0);
        pixel_valid_in = 1'b0;
        send_cnt++;
        if (track) exp_q.push_back('{data: d, last: l, acc: acc});
    endtask

    task automatic wait_high(output int c);
        int n;
        c = -1;
        for (n = 0; n < 20000; n++) begin
            if (ws2812_data_out) begin c = cyc; break; end
            @(negedge clk);
        end
        check("rise_seen", c >= 0, 1);
    endtask

    task automatic run_len(input bit lvl, output int n);
        n = 0;
        while (ws2812_data_out == lvl && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_until(input int t, output int lh, output int hc);
        lh = -1; hc = 0;
        while (cyc < t) begin
            if (ws2812_data_out) begin lh = cyc; hc++; end
            @(negedge clk);
        end
    endtask

    task automatic wait_frame(output int f, output int lh);
        f = -1; lh = -1;
        for (int n = 0; n < 40000; n++) begin
            if (ws2812_data_out) lh = cyc;
            if (frame_done_out) begin f = cyc; break; end
            @(negedge clk);
        end
        check("frame_done_seen", f >= 0, 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: cycle limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, k2, r, r2, f, f2, lh, hc, a0, u0, gap, n;
        rst_in = 1'b1; pixel_valid_in = 1'b0; pixel_data_in = '0; pixel_last_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", ws2812_data_out, 0);
        check("reset_busy", busy_out, 0);
        check("reset_ready", pixel_ready_out, 0);
        check("reset_done", frame_done_out, 0);
        check("reset_underrun", underrun_out, 0);
        rst_in = 1'b0;
        @(negedge clk);
        check("ready_after_release", pixel_ready_out, 1);

        // Reset in the middle of bit 10 of a word, with a second word held.
        send(24'h123456, 1'b0, 1'b0, 1'b0, k);
        send(24'hFEDCBA, 1'b1, 1'b0, 1'b0, k2);
        r = k + 2;
        wait_until(r + 13 * BITC + 50, lh, hc);
        rst_in = 1'b1;
        @(negedge clk);
        check("midbit_reset_data", ws2812_data_out, 0);
        check("midbit_reset_busy", busy_out, 0);
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        check("midbit_ready_after_release", pixel_ready_out, 1);
        wait_until(cyc + 300, lh, hc);
        check("held_word_discarded", hc, 0);
        check("busy_idle_after_reset", busy_out, 0);

        // Single last word; next frame's word presented during the latch.
        send(24'hA50000, 1'b1, 1'b1, 1'b0, k);
        wait_high(r);
        check("idle_latency", r - k, 2);
        run_len(1'b1, n); check("bit23_high", n, T1H);
        run_len(1'b0, n); check("bit23_low", n, BITC - T1H);
        run_len(1'b1, n); check("bit22_high", n, T0H);
        run_len(1'b0, n); check("bit22_low", n, BITC - T0H);
        wait_until(r + WORD + 1000, lh, hc);
        check("word_last_high_cycle", lh, r + WORD - BITC + T0H - 1);
        send(24'h3C5A96, 1'b1, 1'b1, 1'b0, k2);
        check("accepted_during_latch", (k2 > r + WORD - 1) && (k2 < r + WORD + RSTC - 1), 1);
        wait_frame(f, lh);
        check("no_high_during_latch", lh, -1);
        check("frame_done_cycle", f - r, WORD + RSTC - 1);   // rise cycle counted as cycle 1
        check("busy_at_done", busy_out, 1);
        @(negedge clk);
        check("done_single_pulse", frame_done_out, 0);
        check("busy_falls_after_done", busy_out, 0);
        wait_high(r2);
        check("next_frame_start_after_done", r2 - f, 2);
        wait_frame(f2, lh);
        check("frame2_done_cycle", f2 - r2, WORD + RSTC - 1);
        @(negedge clk);

        // Three words, valid held continuously.
        a0 = acc_cnt; u0 = und_cnt;
        send(24'hFFFFFF, 1'b0, 1'b1, 1'b0, k);
        send(24'h000000, 1'b0, 1'b1, 1'b0, k2);
        send(24'h0F0F0F, 1'b1, 1'b1, 1'b0, k2);
        r = k + 2;
        wait_frame(f, lh);
        check("burst_accepts", acc_cnt - a0, 3);
        check("burst_last_high_cycle", lh, r + 3 * WORD - BITC + T1H - 1);
        check("burst_done_cycle", f - r, 3 * WORD + RSTC - 1);
        check("burst_no_underrun", und_cnt - u0, 0);
        @(negedge clk);

        // Underrun: second word arrives 500 cycles after the first one ends.
        u0 = und_cnt;
        send(24'h800000, 1'b0, 1'b1, 1'b0, k);
        r = k + 2;
        wait_until(r + WORD + 500, lh, hc);
        check("stall_line_low", lh, r + WORD - BITC + T0H - 1);
        check("underrun_cycle", last_und, r + WORD - 1);
        check("underrun_once", und_cnt - u0, 1);
        send(24'h5AC3E1, 1'b0, 1'b1, 1'b0, k2);
        wait_high(r2);
        check("stall_resume_latency", r2 - k2, 2);

        // Randomised words and gaps; short gaps also wiggle data while not ready.
        for (int w = 0; w < 6; w++) begin
            gap = $urandom_range(0, 3000);
            repeat (gap) @(negedge clk);
            send(24'($urandom), (w == 5), 1'b1, (gap < 200), k);
        end
        for (n = 0; n < 40000 && exp_q.size() != 0; n++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        wait_frame(f, lh);
        @(negedge clk);

        check("frame_done_count", done_cnt, exp_done);
        check("frame_done_total", done_cnt, 4);
        check("underrun_count", und_cnt, exp_underrun);
        check("accept_count", acc_cnt, send_cnt);
        check("unstable_hold_seen", viol, inj);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
